// File: rtl/skolem_sweep_if.sv
// Handshake and result bundle between the sweep controller and the harness
// that hosts the combinational Skolem block.
interface skolem_sweep_if #(
    parameter int N_IN  = 4,
    parameter int CNT_W = N_IN + 1
);
    logic             start;
    logic             abort;
    logic [N_IN-1:0]  vec_out;
    logic             sk_in;
    logic             spec_ok;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] fail_cnt;
    logic             first_fail_valid;
    logic [N_IN-1:0]  first_fail_vec;
    logic             first_fail_sk;

    modport master (
        input  start, abort, sk_in, spec_ok,
        output vec_out, busy, done, pass, fail_cnt,
               first_fail_valid, first_fail_vec, first_fail_sk
    );

    modport slave (
        output start, abort, sk_in, spec_ok,
        input  vec_out, busy, done, pass, fail_cnt,
               first_fail_valid, first_fail_vec, first_fail_sk
    );
endinterface

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive input sweep for a combinational Skolem block: drives each vector,
// waits SETTLE cycles, samples spec_ok/sk_in, tallies failures and reports pass.
module skolem_sweep_ctrl #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 0,
    parameter int CNT_W  = N_IN + 1
) (
    input  logic           clk,
    input  logic           rst,
    skolem_sweep_if.master bus
);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [7:0]      SETTLE_L = 8'(SETTLE);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    state_t           state_q, state_n;
    logic [N_IN-1:0]  vec_q, vec_n;
    logic [7:0]       settle_q, settle_n;
    logic [CNT_W-1:0] fail_q, fail_n;
    logic             pass_q, pass_n;
    logic             ffv_q, ffv_n;
    logic [N_IN-1:0]  ffvec_q, ffvec_n;
    logic             ffsk_q, ffsk_n;

    always_comb begin
        state_n  = state_q;
        vec_n    = vec_q;
        settle_n = settle_q;
        fail_n   = fail_q;
        pass_n   = pass_q;
        ffv_n    = ffv_q;
        ffvec_n  = ffvec_q;
        ffsk_n   = ffsk_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n  = SWEEP;
                    vec_n    = '0;
                    settle_n = '0;
                    fail_n   = '0;
                    pass_n   = 1'b0;
                    ffv_n    = 1'b0;
                    ffvec_n  = '0;
                    ffsk_n   = 1'b0;
                end
            end
            SWEEP: begin
                // Abort wins over the sample; the partial tally stays visible.
                if (bus.abort) begin
                    state_n = IDLE;
                    pass_n  = 1'b0;
                end else if (settle_q != SETTLE_L) begin
                    settle_n = settle_q + 8'd1;
                end else begin
                    if (!bus.spec_ok) begin
                        fail_n = fail_q + CNT_W'(1);
                        if (!ffv_q) begin
                            ffv_n   = 1'b1;
                            ffvec_n = vec_q;
                            ffsk_n  = bus.sk_in;
                        end
                    end
                    // Last vector leaves vec_out parked at all-ones.
                    if (vec_q == VEC_LAST) begin
                        state_n = DONE;
                        pass_n  = (fail_n == '0);
                    end else begin
                        vec_n    = vec_q + N_IN'(1);
                        settle_n = '0;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q    <= '0;
            settle_q <= '0;
            fail_q   <= '0;
            pass_q   <= 1'b0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
            ffsk_q   <= 1'b0;
        end else begin
            vec_q    <= vec_n;
            settle_q <= settle_n;
            fail_q   <= fail_n;
            pass_q   <= pass_n;
            ffv_q    <= ffv_n;
            ffvec_q  <= ffvec_n;
            ffsk_q   <= ffsk_n;
        end
    end

    assign bus.vec_out          = vec_q;
    assign bus.busy             = (state_q == SWEEP);
    assign bus.done             = (state_q == DONE);
    assign bus.pass             = pass_q;
    assign bus.fail_cnt         = fail_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;
    assign bus.first_fail_sk    = ffsk_q;
endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Bench for skolem_sweep_ctrl: one instance with SETTLE=0 driven from a sweep
// table plus corner sequences, and one with SETTLE=2 for the settle timing.
module tb_skolem_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;
    logic ok2 = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    skolem_sweep_if #(.N_IN(4), .CNT_W(5)) b0 ();
    skolem_sweep_if #(.N_IN(4), .CNT_W(5)) b2 ();

    skolem_sweep_ctrl #(.N_IN(4), .SETTLE(0), .CNT_W(5)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    skolem_sweep_ctrl #(.N_IN(4), .SETTLE(2), .CNT_W(5)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    // Stand-in Skolem block and formula checker, selected by mode.
    always_comb begin
        b0.sk_in   = ^b0.vec_out;
        b0.spec_ok = 1'b1;
        case (mode)
            1: begin b0.sk_in = 1'b1; b0.spec_ok = (b0.vec_out != 4'd5); end
            2: b0.spec_ok = 1'b0;
            3: b0.spec_ok = !(b0.vec_out == 4'd3 || b0.vec_out == 4'd12);
            default: ;
        endcase
    end

    always_comb begin
        b2.sk_in   = 1'b0;
        b2.spec_ok = ok2;
    end

    typedef struct {
        int mode;
        int abort_vec;
        int exp_fail;
        int exp_ffv;
        int exp_ffvec;
        int exp_ffsk;
        int exp_pass;
        int exp_done;
        int exp_busy;
        int exp_vec;
    } sweep_vec_t;

    sweep_vec_t tbl[6];
    sweep_vec_t sb_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else            n_pass++;
    endtask

    task automatic run_entry(input sweep_vec_t e);
        sweep_vec_t x;
        int busy_n  = 0;
        int done_n  = 0;
        int done_at = -1;
        int bad_vec = 0;
        sb_q.push_back(e);
        @(negedge clk);
        mode     = e.mode;
        b0.start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            b0.start = 1'b0;
            b0.abort = 1'b0;
            if (b0.busy) begin
                busy_n++;
                if (int'(b0.vec_out) != c - 1) bad_vec++;
                if (e.abort_vec == c - 1) b0.abort = 1'b1;
            end
            if (b0.done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
        end
        x = sb_q.pop_front();
        chk("busy_cycles", busy_n, x.exp_busy);
        chk("vec_seq_bad", bad_vec, 0);
        chk("done_cycle", done_at, x.exp_done ? 17 : -1);
        chk("done_pulses", done_n, x.exp_done);
        chk("fail_cnt", int'(b0.fail_cnt), x.exp_fail);
        chk("first_fail_valid", int'(b0.first_fail_valid), x.exp_ffv);
        chk("first_fail_vec", int'(b0.first_fail_vec), x.exp_ffvec);
        chk("first_fail_sk", int'(b0.first_fail_sk), x.exp_ffsk);
        chk("pass", int'(b0.pass), x.exp_pass);
        chk("vec_out_final", int'(b0.vec_out), x.exp_vec);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vec_out"}, int'(b0.vec_out), 0);
        chk({tag, "_busy"}, int'(b0.busy), 0);
        chk({tag, "_done"}, int'(b0.done), 0);
        chk({tag, "_pass"}, int'(b0.pass), 0);
        chk({tag, "_fail_cnt"}, int'(b0.fail_cnt), 0);
        chk({tag, "_ffv"}, int'(b0.first_fail_valid), 0);
        chk({tag, "_ffvec"}, int'(b0.first_fail_vec), 0);
        chk({tag, "_ffsk"}, int'(b0.first_fail_sk), 0);
    endtask

    initial begin
        int busy_n;
        int done_n;
        int done_at;
        int bad_vec;
        int hit;

        //            mode abort fail ffv ffvec ffsk pass done busy vec
        tbl[0] = '{0, -1,  0, 0, 0, 0, 1, 1, 16, 15};
        tbl[1] = '{1, -1,  1, 1, 5, 1, 0, 1, 16, 15};
        tbl[2] = '{2, -1, 16, 1, 0, 0, 0, 1, 16, 15};
        tbl[3] = '{3, -1,  2, 1, 3, 0, 0, 1, 16, 15};
        tbl[4] = '{2,  7,  7, 1, 0, 0, 0, 0,  8,  7};
        tbl[5] = '{0, -1,  0, 0, 0, 0, 1, 1, 16, 15};

        b0.start = 1'b0; b0.abort = 1'b0;
        b2.start = 1'b0; b2.abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        chk("reset_b2_busy", int'(b2.busy), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_entry(tbl[i]);

        // start pulses during SWEEP and during the DONE cycle must be ignored
        mode    = 0;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        @(negedge clk);
        b0.start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            b0.start = (c == 5 || c == 17) ? 1'b1 : 1'b0;
            if (b0.busy) busy_n++;
            if (b0.done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
        end
        b0.start = 1'b0;
        chk("ign_busy_cycles", busy_n, 16);
        chk("ign_done_pulses", done_n, 1);
        chk("ign_done_cycle", done_at, 17);
        chk("ign_pass", int'(b0.pass), 1);

        // reset together with start in the middle of a failing sweep
        mode = 2;
        hit  = 0;
        @(negedge clk);
        b0.start = 1'b1;
        for (int c = 1; c <= 30 && hit == 0; c++) begin
            @(negedge clk);
            b0.start = 1'b0;
            if (b0.busy && b0.vec_out == 4'd9) begin
                hit = 1;
                chk("pre_rst_fail_cnt", int'(b0.fail_cnt), 9);
                rst      = 1'b1;
                b0.start = 1'b1;
            end
        end
        chk("rst_point_reached", hit, 1);
        @(negedge clk);
        rst      = 1'b0;
        b0.start = 1'b0;
        chk_reset_vals("rst_start");
        busy_n = 0;
        done_n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b0.busy) busy_n++;
            if (b0.done) done_n++;
        end
        chk("post_rst_busy", busy_n, 0);
        chk("post_rst_done", done_n, 0);

        // SETTLE=2 with spec_ok low outside the sample cycles
        busy_n  = 0;
        done_at = -1;
        bad_vec = 0;
        @(negedge clk);
        b2.start = 1'b1;
        ok2      = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            b2.start = 1'b0;
            ok2 = ((c - 1) % 3 == 2) ? 1'b1 : 1'b0;
            if (b2.busy) begin
                busy_n++;
                if (int'(b2.vec_out) != (c - 1) / 3) bad_vec++;
            end
            if (b2.done && done_at < 0) done_at = c;
        end
        chk("s2_busy_cycles", busy_n, 48);
        chk("s2_vec_seq_bad", bad_vec, 0);
        chk("s2_done_cycle", done_at, 49);
        chk("s2_fail_cnt", int'(b2.fail_cnt), 0);
        chk("s2_pass", int'(b2.pass), 1);
        chk("s2_ffv", int'(b2.first_fail_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/skolem_sweep_ctrl.md
Name: skolem_sweep_ctrl

Overview:
Sequencer that exhaustively drives every input assignment into one combinational Skolem-function block, such as an ABC-generated SKOLEMFORMULA netlist. It waits a programmable settle time per vector, then samples the Skolem output together with an externally computed formula-satisfied flag. It counts failures, records the first failing vector, and reports pass/done. It sits in the bench-side harness that validates invertibility-condition Skolem functions after each synthesis run.

Parameters:
N_IN, 4, number of Skolem-function inputs to enumerate (vector width)
SETTLE, 0, extra wait cycles per vector before sampling (0..255)
CNT_W, N_IN+1, failure counter width; must hold 2^N_IN

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a sweep; accepted only in IDLE
abort  input  1  terminate a running sweep; effective only in SWEEP
vec_out  output  N_IN  input vector driven to the Skolem block (registered)
sk_in  input  1  Skolem-block output for vec_out
spec_ok  input  1  1 = formula holds for (vec_out, sk_in)
busy  output  1  high while in SWEEP
done  output  1  one-cycle pulse at normal sweep completion
pass  output  1  1 = last completed sweep had zero failures; held until next accepted start
fail_cnt  output  CNT_W  number of vectors with spec_ok=0 in current/last sweep
first_fail_valid  output  1  at least one failure captured
first_fail_vec  output  N_IN  vec_out at first failure
first_fail_sk  output  1  sk_in at first failure

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE; vec_out=0; busy=0; done=0; pass=0; fail_cnt=0; first_fail_valid=0; first_fail_vec=0; first_fail_sk=0; settle counter=0. Reset overrides start and abort in the same cycle.
- States: IDLE, SWEEP, DONE.
- IDLE: start=1 -> SWEEP. On the same edge: vec_out=0, settle_cnt=0, fail_cnt=0, first_fail_* cleared, pass=0, busy=1. abort is ignored in IDLE.
- SWEEP, settle_cnt<SETTLE: settle_cnt++; no sampling.
- SWEEP, settle_cnt==SETTLE (sample cycle):
  - If spec_ok=0: fail_cnt++.
  - If spec_ok=0 and first_fail_valid=0: capture first_fail_vec=vec_out and first_fail_sk=sk_in, then set first_fail_valid=1.
  - If vec_out is all-ones: go to DONE and do not wrap vec_out.
  - Otherwise: vec_out++ and settle_cnt=0.
- SWEEP, abort=1: takes priority over sampling that cycle -> IDLE; busy=0; done stays 0; pass=0; fail_cnt and first_fail_* keep their current values.
- start while busy or in DONE: ignored, no restart.
- DONE: lasts exactly one cycle.
  - done=1 and busy=0 during that cycle.
  - pass=(fail_cnt==0) is registered on entry to DONE.
  - Next state is IDLE.
  - vec_out holds all-ones until the next start.
- Timing, start sampled at edge k:
  - busy=1 in cycle k+1.
  - Vector j sampled in cycle k+1+j*(SETTLE+1)+SETTLE.
  - done=1 in cycle k+1+2^N_IN*(SETTLE+1).
- fail_cnt never wraps, since CNT_W ≥ N_IN+1.
- The Skolem block is combinational. sk_in and spec_ok must be valid in the sample cycle and are not registered before use.

Test Plan:
- N_IN=4, SETTLE=0, spec_ok tied 1, start pulse at cycle 0 -> busy cycles 1..16; done=1 at cycle 17; pass=1; fail_cnt=0; first_fail_valid=0; vec_out stays 4'hF.
- spec_ok=0 only when vec_out==4'b0101, sk_in=1 -> fail_cnt=1; first_fail_vec=5; first_fail_sk=1; pass=0; done at cycle 17.
- spec_ok tied 0 -> fail_cnt=16; first_fail_vec=0; pass=0.
- SETTLE=2, spec_ok=1 -> vec_out changes every 3 cycles; done at cycle 49; only sample cycles affect counts (glitch spec_ok low in non-sample cycles -> fail_cnt=0).
- abort asserted while vec_out==7 -> IDLE next cycle; busy=0; done never pulses; pass=0. A new start restarts at vec_out=0 with counters cleared.
- rst pulsed at vec_out==9 concurrent with start -> all outputs at reset values; no sweep starts. A start during SWEEP or DONE is ignored, giving exactly one done pulse.
